// File: rtl/astar_open_list.sv
// Sorted open list for the A* engine: DEPTH entries kept in ascending f-cost order, minimum at slot 0.
// Optional duplicate-node merging is enabled by defining ASTAR_OPEN_DEDUP_EN.
module astar_open_list #(
    parameter int COST_W = 12,
    parameter int NODE_W = 10,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              sync,
    input  logic              reset,
    input  logic              flush,
    input  logic              ins_en,
    input  logic [COST_W-1:0] ins_cost,
    input  logic [NODE_W-1:0] ins_node,
    input  logic              pop_en,
    output logic              head_valid,
    output logic [COST_W-1:0] head_cost,
    output logic [NODE_W-1:0] head_node,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              drop,
    output logic [NODE_W-1:0] drop_node,
    output logic              dup_hit
);

    typedef struct packed {
        logic              valid;
        logic [COST_W-1:0] cost;
        logic [NODE_W-1:0] node;
    } entry_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    entry_t            slot_q [DEPTH];
    entry_t            slot_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              drop_q, drop_d;
    logic [NODE_W-1:0] drop_node_q, drop_node_d;
    logic              dup_hit_q, dup_hit_d;

    entry_t            post_pop [DEPTH];
    entry_t            base [DEPTH];
    entry_t            new_entry;
    logic [DEPTH-1:0]  le;
    logic [CNT_W-1:0]  cnt_p, cnt_base;
    logic              do_pop, do_ins, base_full;
`ifdef ASTAR_OPEN_DEDUP_EN
    logic              match_any;
    logic              seen;
    logic [COST_W-1:0] match_cost;
`endif

    // ins_en and pop_en are fire-and-forget requests: each is taken on every rising edge, there is no ready.
    always_comb begin
        do_pop = pop_en && slot_q[0].valid;
        cnt_p  = count_q;
        for (int i = 0; i < DEPTH; i++) post_pop[i] = slot_q[i];
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) post_pop[i] = slot_q[i + 1];
            post_pop[DEPTH-1] = '0;
            cnt_p = count_q - CNT_W'(1);
        end

        for (int i = 0; i < DEPTH; i++) base[i] = post_pop[i];
        cnt_base  = cnt_p;
        do_ins    = ins_en;
        dup_hit_d = 1'b0;

`ifdef ASTAR_OPEN_DEDUP_EN
        match_any  = 1'b0;
        match_cost = '0;
        seen       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!match_any && post_pop[i].valid && (post_pop[i].node == ins_node)) begin
                match_any  = 1'b1;
                match_cost = post_pop[i].cost;
            end
        end
        if (ins_en && match_any) begin
            dup_hit_d = 1'b1;
            if (ins_cost < match_cost) begin
                // Close the gap left by the stale entry; the last slot is always freed.
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (!seen && post_pop[i].valid && (post_pop[i].node == ins_node)) seen = 1'b1;
                    if (seen) base[i] = post_pop[i + 1];
                end
                base[DEPTH-1] = '0;
                cnt_base = cnt_p - CNT_W'(1);
            end else begin
                do_ins = 1'b0;
            end
        end
`endif

        new_entry.valid = 1'b1;
        new_entry.cost  = ins_cost;
        new_entry.node  = ins_node;
        base_full = (cnt_base == DEPTH_C);
        // le is a prefix mask: slots that stay ahead of the new entry (ties keep FIFO order).
        for (int i = 0; i < DEPTH; i++) le[i] = base[i].valid && (base[i].cost <= ins_cost);

        for (int i = 0; i < DEPTH; i++) slot_d[i] = base[i];
        count_d     = cnt_base;
        drop_d      = 1'b0;
        drop_node_d = '0;

        if (do_ins) begin
            if (base_full && le[DEPTH-1]) begin
                drop_d      = 1'b1;
                drop_node_d = ins_node;
            end else begin
                if (base_full) begin
                    drop_d      = 1'b1;
                    drop_node_d = base[DEPTH-1].node;
                end else begin
                    count_d = cnt_base + CNT_W'(1);
                end
                if (!le[0]) slot_d[0] = new_entry;
                for (int i = 1; i < DEPTH; i++) begin
                    if (!le[i]) slot_d[i] = le[i-1] ? new_entry : base[i-1];
                end
            end
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
            count_d     = '0;
            drop_d      = 1'b0;
            drop_node_d = '0;
            dup_hit_d   = 1'b0;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
    end

    always_ff @(posedge sync or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            drop_q      <= 1'b0;
            drop_node_q <= '0;
            dup_hit_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            drop_q      <= drop_d;
            drop_node_q <= drop_node_d;
            dup_hit_q   <= dup_hit_d;
        end
    end

    assign head_valid = slot_q[0].valid;
    assign head_cost  = slot_q[0].cost;
    assign head_node  = slot_q[0].node;
    assign count      = count_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign drop       = drop_q;
    assign drop_node  = drop_node_q;
    assign dup_hit    = dup_hit_q;

endmodule
